data_cache: RTL
===============

# data_cache

Direct-mapped, write-through, no-write-allocate data cache sitting in the memory stage, directly after the execute/memory pipeline register. It answers loads and stores presented by the memory stage, issues line refills and word writes to main memory over a req/ack interface, and drives `stall_cache`, which freezes the upstream pipeline registers while an access is outstanding.

## Interface
- `SETS`, 64, number of lines (power of two, ≥2)
- `LINE_WORDS`, 4, 32-bit words per line (power of two, ≥1)
- `clk` input 1: clock, all state updates on rising edge
- `rst_n` input 1: synchronous, active-low reset
- `MemReadM` input 1: load request this cycle
- `MemWriteM` input 1: store request this cycle (wins if both set)
- `ALUoutM` input 32: byte address
- `funct3M` input 3: RV32I size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW)
- `Rd2M` input 32: store data, LSB-aligned
- `ReadDataM` output 32: extended load result, valid when `MemReadM` and `stall_cache`=0
- `stall_cache` output 1: hold pipeline this cycle
- `mem_req` output 1: memory request
- `mem_we` output 1: 1 write, 0 read
- `mem_addr` output 32: word-aligned address (bits [1:0]=0)
- `mem_wdata` output 32: write data, byte lanes already positioned
- `mem_wstrb` output 4: byte enables for writes, 0 on reads
- `mem_rdata` input 32: read data, valid with `mem_ack`
- `mem_ack` input 1: one-cycle completion pulse, only while `mem_req`=1

## Operation
- Address split: [1:0] byte, next log2(LINE_WORDS) bits word, next log2(SETS) bits index, remainder tag.
- Per line: valid bit, tag, LINE_WORDS data words. Reset clears all valid bits; data/tag not reset.
- States: IDLE, REFILL, WRITE, WDONE. Reset → IDLE; outputs reset to `mem_req`=0, `mem_we`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0; refill counter 0.
- IDLE, load hit: `ReadDataM` from cache combinationally, `stall_cache`=0, stay IDLE.
- IDLE, load miss: `stall_cache`=1, → REFILL with counter=0.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={tag,index,counter,2'b00}. On `mem_ack` write `mem_rdata` into word[counter], counter++. Ack on last word: set valid, write tag, → IDLE. `stall_cache`=1 throughout.
- IDLE, store (hit or miss): `stall_cache`=1, → WRITE.
- WRITE: `mem_req`=1, `mem_we`=1, address/`mem_wdata`/`mem_wstrb` from the held request; held stable until `mem_ack`. On ack: if line valid and tag matches, merge enabled bytes into the cached word; → WDONE. `stall_cache`=1.
- WDONE: `stall_cache`=0, `mem_req`=0, no memory or cache action; → IDLE. Prevents re-issuing the same store.
- Store lanes: SB replicates byte, strobe 1<<addr[1:0]; SH replicates halfword, strobe 0011 or 1100 by addr[1]; SW strobe 1111.
- Load extraction: LB/LBU select byte addr[1:0], LH/LHU select halfword addr[1], LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
- Misalignment not checked: halfword ignores addr[0], word ignores addr[1:0]. Undefined funct3 treated as LW/SW.
- No request (both strobes 0): `stall_cache`=0, `ReadDataM`=0.

## Timing
- Load hit: 0 added cycles.
- Load miss: 1 cycle IDLE detect + LINE_WORDS acks in REFILL + 1 IDLE hit cycle; stall drops in that hit cycle.
- Store: 1 IDLE cycle + cycles to ack in WRITE + WDONE (stall low in WDONE). Zero-wait memory: store stalls exactly 2 cycles.
- Inputs must stay stable while `stall_cache`=1 (guaranteed by upstream hold).
- `mem_req` never deasserts before `mem_ack` except on reset.
- Reset mid-REFILL/WRITE: next cycle IDLE, `mem_req`=0, partially filled line stays invalid; a late `mem_ack` is ignored.

## Test plan
- Reset, then LW 0x100, memory returns 0x11,0x22,0x33,0x44 for 0x100..0x10C → 4 read reqs at 0x100..0x10C, then `ReadDataM`=0x11 with `stall_cache`=0; next LW 0x108 hits, returns 0x33, no stall.
- Line holds 0x8081_F2F3 at 0x200: LB 0x200 → 0xFFFF_FFF3; LBU 0x203 → 0x80; LH 0x202 → 0xFFFF_8081; LHU 0x200 → 0xF2F3.
- SB 0x201 with `Rd2M`=0xAB, line cached → write req `mem_wstrb`=0010, `mem_wdata`=0xABAB_ABAB; after WDONE, LW 0x200 hits and returns 0x8081_ABF3.
- SW 0x400 to uncached line → one write req, no refill, line stays invalid; following LW 0x400 misses and refills.
- Memory with 3-cycle ack delay on a store: `mem_addr`/`mem_wdata`/`mem_wstrb` stable all wait cycles, exactly one ack consumed, `stall_cache` low for exactly one cycle (WDONE).
- `rst_n`=0 after 2nd refill ack → `mem_req`=0 next cycle; retrying the same LW misses and performs a full 4-word refill.

Source files
------------

// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_if
// Brief    : Memory-stage request bus and main-memory req/ack bus of the data cache
// Revision : 1.0
// ============================================================================
interface data_cache_if;
   logic        MemReadM;
   logic        MemWriteM;
   logic [31:0] ALUoutM;
   logic [2:0]  funct3M;
   logic [31:0] Rd2M;
   logic [31:0] ReadDataM;
   logic        stall_cache;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  MemReadM, MemWriteM, ALUoutM, funct3M, Rd2M,
      output ReadDataM, stall_cache,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata, mem_ack
   );

   modport master (
      output MemReadM, MemWriteM, ALUoutM, funct3M, Rd2M,
      input  ReadDataM, stall_cache,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata, mem_ack
   );
endinterface
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Brief    : Direct-mapped, write-through, no-write-allocate data cache
// Revision : 1.0
// ============================================================================
module data_cache #(
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   data_cache_if.slave bus
);
   localparam int c_OFFW  = $clog2(LINE_WORDS);
   localparam int c_IDXW  = $clog2(SETS);
   localparam int c_SLOTW = c_OFFW + c_IDXW;
   localparam int c_TAGW  = 30 - c_SLOTW;
   localparam int c_CNTW  = (c_OFFW > 0) ? c_OFFW : 1;
   localparam int c_DEPTH = SETS * LINE_WORDS;
   localparam logic [31:0] c_LINE_MASK = 32'(LINE_WORDS * 4 - 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_REFILL = 2'd1;
   localparam logic [1:0] c_WRITE  = 2'd2;
   localparam logic [1:0] c_WDONE  = 2'd3;

   logic [1:0]        r_state;
   logic [c_CNTW-1:0] r_cnt;
   logic [SETS-1:0]   r_valid;
   logic [c_TAGW-1:0] r_tag  [SETS];
   logic [31:0]       r_data [c_DEPTH];
   logic              r_mem_req;
   logic              r_mem_we;
   logic [31:0]       r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_wstrb;

   logic [c_SLOTW-1:0] w_cpu_slot, w_mem_slot;
   logic [c_IDXW-1:0]  w_cpu_idx, w_mem_idx;
   logic [c_TAGW-1:0]  w_cpu_tag, w_mem_tag;
   logic               w_hit, w_wr_hit, w_load, w_store, w_last, w_stall;
   logic [31:0]        w_word, w_rdata, w_st_data, w_dval;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [3:0]         w_st_strb;
   logic               w_dwe, w_tag_we;

   // Slot = {index, word}: the bits just above the byte offset address the data array
   assign w_cpu_slot = bus.ALUoutM[2 +: c_SLOTW];
   assign w_cpu_idx  = bus.ALUoutM[2 + c_OFFW +: c_IDXW];
   assign w_cpu_tag  = bus.ALUoutM[31 -: c_TAGW];
   assign w_mem_slot = r_mem_addr[2 +: c_SLOTW];
   assign w_mem_idx  = r_mem_addr[2 + c_OFFW +: c_IDXW];
   assign w_mem_tag  = r_mem_addr[31 -: c_TAGW];

   assign w_hit    = r_valid[w_cpu_idx] && (r_tag[w_cpu_idx] == w_cpu_tag);
   assign w_wr_hit = r_valid[w_mem_idx] && (r_tag[w_mem_idx] == w_mem_tag);
   assign w_store  = bus.MemWriteM;
   assign w_load   = bus.MemReadM && !bus.MemWriteM;
   assign w_last   = (r_cnt == c_CNTW'(LINE_WORDS - 1));

   assign w_word = r_data[w_cpu_slot];
   assign w_byte = w_word[{bus.ALUoutM[1:0], 3'b000} +: 8];
   assign w_half = bus.ALUoutM[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_rdata = '0;
      if (w_load) begin
         case (bus.funct3M)
            3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
            3'b100:  w_rdata = {24'd0, w_byte};
            3'b101:  w_rdata = {16'd0, w_half};
            default: w_rdata = w_word;
         endcase
      end
   end

   always_comb begin
      w_st_data = bus.Rd2M;
      w_st_strb = 4'b1111;
      case (bus.funct3M)
         3'b000: begin
            w_st_data = {4{bus.Rd2M[7:0]}};
            w_st_strb = 4'b0001 << bus.ALUoutM[1:0];
         end
         3'b001: begin
            w_st_data = {2{bus.Rd2M[15:0]}};
            w_st_strb = bus.ALUoutM[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (r_state)
         c_IDLE:   w_stall = w_store || (w_load && !w_hit);
         c_REFILL: w_stall = 1'b1;
         c_WRITE:  w_stall = 1'b1;
         default:  w_stall = 1'b0;
      endcase
   end

   // Cache array writes: refill words, and byte merge of a store that hits
   always_comb begin
      w_dwe    = 1'b0;
      w_tag_we = 1'b0;
      w_dval   = r_data[w_mem_slot];
      if (r_state == c_REFILL && bus.mem_ack) begin
         w_dwe    = 1'b1;
         w_tag_we = w_last;
         w_dval   = bus.mem_rdata;
      end else if (r_state == c_WRITE && bus.mem_ack && w_wr_hit) begin
         w_dwe = 1'b1;
         for (int b = 0; b < 4; b++) begin
            if (r_mem_wstrb[b]) w_dval[8*b +: 8] = r_mem_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_dwe)    r_data[w_mem_slot] <= w_dval;
      if (w_tag_we) r_tag[w_mem_idx]   <= w_mem_tag;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_cnt       <= '0;
         r_valid     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_store) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= {bus.ALUoutM[31:2], 2'b00};
                  r_mem_wdata <= w_st_data;
                  r_mem_wstrb <= w_st_strb;
                  r_state     <= c_WRITE;
               end else if (w_load && !w_hit) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_wstrb <= '0;
                  r_mem_addr  <= bus.ALUoutM & ~c_LINE_MASK;
                  r_cnt       <= '0;
                  r_state     <= c_REFILL;
               end
            end
            c_REFILL: begin
               if (bus.mem_ack) begin
                  r_cnt      <= r_cnt + 1'b1;
                  r_mem_addr <= r_mem_addr + 32'd4;
                  if (w_last) begin
                     r_mem_req          <= 1'b0;
                     r_valid[w_mem_idx] <= 1'b1;
                     r_state            <= c_IDLE;
                  end
               end
            end
            c_WRITE: begin
               if (bus.mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_wstrb <= '0;
                  r_state     <= c_WDONE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign bus.ReadDataM   = w_rdata;
   assign bus.stall_cache = w_stall;
   assign bus.mem_req     = r_mem_req;
   assign bus.mem_we      = r_mem_we;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_wdata   = r_mem_wdata;
   assign bus.mem_wstrb   = r_mem_wstrb;
endmodule
`default_nettype wire
